// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: address map defaults and ExcCode values.
// Used by the IF stage, the D/E/M stage registers and CP0.
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
    localparam logic [31:0] IM_TOP_DEF     = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // Sequential fetch step; 32-bit modulo so it wraps silently.
    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Word-access address check: misaligned or outside [BASE, TOP] faults.
// Shared by the IF fetch path and the M-stage load check.
module fetch_addr_check
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE = IM_BASE_DEF,
    parameter logic [31:0] TOP  = IM_TOP_DEF
) (
    input  logic [31:0] pc,
    output logic        adel
);

    // Fault on low-bit misalignment or an out-of-window address.
    always_comb begin
        adel = (pc[1:0] != 2'b00) || (pc < BASE) || (pc > TOP);
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, fetch with AdEL detection and BD flag.
// Optional FETCH_PERF_CNT_EN adds fetch/stall/redirect cycle counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] IM_BASE    = IM_BASE_DEF,
    parameter logic [31:0] IM_TOP     = IM_TOP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        branch_d,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_f,
    output logic [31:0] pc8_f,
    output logic [31:0] ir_f,
    output logic        bd_f,
    output logic [4:0]  exc_f
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] redir_cnt
`endif
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        adel;
    logic        cp0_redir;

    assign cp0_redir = exc_req | eret_req;

    // Next-PC select; reset is synchronous so it simply wins the mux.
    always_comb begin
        pc_d = pc_next_seq(pc_q);
        if (reset) begin
            pc_d = PC_RESET;
        end else if (exc_req) begin
            pc_d = EXC_VECTOR;
        end else if (eret_req) begin
            pc_d = epc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    fetch_addr_check #(
        .BASE (IM_BASE),
        .TOP  (IM_TOP)
    ) u_addr_check (
        .pc   (pc_q),
        .adel (adel)
    );

    // Fetch outputs; a faulting fetch is squashed to a nop.
    always_comb begin
        imem_addr = pc_q;
        pc_f      = pc_q;
        pc8_f     = pc_q + 32'd8;
        ir_f      = adel ? 32'd0 : imem_rdata;
        exc_f     = adel ? EXC_ADEL : EXC_NONE;
        bd_f      = branch_d & ~cp0_redir;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;
    logic        advance;

    assign advance = ~stall & ~cp0_redir;

    // Counter next-state; CP0 redirects count as neither fetch nor stall.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (reset) begin
            fetch_cnt_d = 32'd0;
            stall_cnt_d = 32'd0;
            redir_cnt_d = 32'd0;
        end else begin
            if (advance) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
            if (stall && !cp0_redir) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (advance && redirect) begin
                redir_cnt_d = redir_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        fetch_cnt_q <= fetch_cnt_d;
        stall_cnt_q <= stall_cnt_d;
        redir_cnt_q <= redir_cnt_d;
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign redir_cnt = redir_cnt_q;
`endif

endmodule
